// File: rtl/pong_sound_pkg.sv
// Shared encodings and default timing constants for the Pong sound path.
// Request vectors are ordered {goal, pad, wall}, so bit 2 is the highest priority.
package pong_sound_pkg;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_WALL = 2'd1,
      SRC_PAD  = 2'd2,
      SRC_GOAL = 2'd3
   } src_t;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   localparam int DEF_GOAL_HALF_PERIOD = 65536;
   localparam int DEF_PAD_HALF_PERIOD  = 32768;
   localparam int DEF_WALL_HALF_PERIOD = 4096;
   localparam int DEF_GOAL_TICKS       = 60;
   localparam int DEF_PAD_TICKS        = 10;
   localparam int DEF_WALL_TICKS       = 6;
   localparam int DEF_DIV_W            = 17;
   localparam int DEF_TICK_W           = 8;

   function automatic src_t top_src(input logic [2:0] v);
      src_t s;
      if (v[2]) begin
         s = SRC_GOAL;
      end else if (v[1]) begin
         s = SRC_PAD;
      end else if (v[0]) begin
         s = SRC_WALL;
      end else begin
         s = SRC_NONE;
      end
      return s;
   endfunction

   function automatic logic [2:0] src_mask(input src_t s);
      logic [2:0] m;
      case (s)
         SRC_WALL: m = 3'b001;
         SRC_PAD:  m = 3'b010;
         SRC_GOAL: m = 3'b100;
         default:  m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: phase counter plus toggle flop.
// While held the phase freezes and the output is parked low.
module tone_gen
   import pong_sound_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             hold,
   input  logic [DIV_W-1:0] half_period,
   output logic             wave
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] phase_q, phase_d;
   logic             wave_q, wave_d;

   always_comb begin
      phase_d = phase_q;
      wave_d  = wave_q;
      if (restart) begin
         phase_d = '0;
         wave_d  = 1'b1;
      end else if (hold) begin
         wave_d  = 1'b0;
      end else if (phase_q == half_period - ONE) begin
         phase_d = '0;
         wave_d  = ~wave_q;
      end else begin
         phase_d = phase_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         wave_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         wave_q  <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/buzz_sequencer.sv
// Shares the piezo pin between goal, paddle and wall sounds with fixed priority,
// one pending slot per source and game_en-timed tone durations.
module buzz_sequencer
   import pong_sound_pkg::*;
#(
   parameter int GOAL_HALF_PERIOD = DEF_GOAL_HALF_PERIOD,
   parameter int PAD_HALF_PERIOD  = DEF_PAD_HALF_PERIOD,
   parameter int WALL_HALF_PERIOD = DEF_WALL_HALF_PERIOD,
   parameter int GOAL_TICKS       = DEF_GOAL_TICKS,
   parameter int PAD_TICKS        = DEF_PAD_TICKS,
   parameter int WALL_TICKS       = DEF_WALL_TICKS,
   parameter int DIV_W            = DEF_DIV_W,
   parameter int TICK_W           = DEF_TICK_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_en,
   input  logic       pause,
   input  logic       goal_hit,
   input  logic       pad_hit,
   input  logic       wall_hit,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] active_src
);

   localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

   state_t            state_q, state_d;
   src_t              src_q, src_d;
   logic              busy_q, busy_d;
   logic [2:0]        pend_q, pend_d;
   logic [TICK_W-1:0] tick_q, tick_d;

   logic [2:0]        req_s, act_mask_s, pend_all_s;
   src_t              grant_s, hi_req_s;
   logic              same_req_s, tone_end_s, restart_s, hold_s, wave_s;
   logic [DIV_W-1:0]  half_s;
   logic [TICK_W-1:0] last_tick_s;

   assign req_s      = pause ? 3'b000 : {goal_hit, pad_hit, wall_hit};
   assign act_mask_s = src_mask(src_q);
   assign pend_all_s = pend_q | (req_s & ~act_mask_s);
   assign hi_req_s   = top_src(req_s);
   assign same_req_s = |(req_s & act_mask_s);
   assign tone_end_s = game_en && (tick_q == last_tick_s) && !same_req_s;

   always_comb begin
      case (src_q)
         SRC_GOAL: begin
            half_s      = DIV_W'(GOAL_HALF_PERIOD);
            last_tick_s = TICK_W'(GOAL_TICKS - 1);
         end
         SRC_PAD: begin
            half_s      = DIV_W'(PAD_HALF_PERIOD);
            last_tick_s = TICK_W'(PAD_TICKS - 1);
         end
         SRC_WALL: begin
            half_s      = DIV_W'(WALL_HALF_PERIOD);
            last_tick_s = TICK_W'(WALL_TICKS - 1);
         end
         default: begin
            half_s      = DIV_W'(WALL_HALF_PERIOD);
            last_tick_s = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= SRC_NONE;
         busy_q  <= 1'b0;
         pend_q  <= 3'b000;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         tick_q  <= tick_d;
      end
   end

   // Grant decision: idle grant, preemption, or chaining a pending source at tone end.
   always_comb begin
      state_d = state_q;
      grant_s = SRC_NONE;
      case (state_q)
         IDLE: begin
            if (pause) begin
               state_d = IDLE;
            end else begin
               grant_s = top_src(pend_all_s);
               state_d = (grant_s != SRC_NONE) ? PLAY : IDLE;
            end
         end
         PLAY: begin
            if (pause) begin
               state_d = PLAY;
            end else if (hi_req_s > src_q) begin
               grant_s = hi_req_s;
            end else if (tone_end_s) begin
               grant_s = top_src(pend_all_s);
               state_d = (grant_s != SRC_NONE) ? PLAY : IDLE;
            end else begin
               state_d = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      src_d     = src_q;
      busy_d    = busy_q;
      pend_d    = pend_all_s;
      tick_d    = tick_q;
      restart_s = 1'b0;
      hold_s    = 1'b0;
      if (pause) begin
         pend_d = pend_q;
         hold_s = 1'b1;
      end else if (grant_s != SRC_NONE) begin
         src_d     = grant_s;
         busy_d    = 1'b1;
         pend_d    = pend_all_s & ~src_mask(grant_s);
         tick_d    = '0;
         restart_s = 1'b1;
      end else if (state_d == IDLE) begin
         src_d  = SRC_NONE;
         busy_d = 1'b0;
         tick_d = '0;
         hold_s = 1'b1;
      end else if (same_req_s) begin
         tick_d = '0;
      end else if (game_en) begin
         tick_d = tick_q + TICK_ONE;
      end else begin
         tick_d = tick_q;
      end
   end

   tone_gen #(
      .DIV_W(DIV_W)
   ) u_tone (
      .clk        (clk),
      .rst        (rst),
      .restart    (restart_s),
      .hold       (hold_s),
      .half_period(half_s),
      .wave       (wave_s)
   );

   assign buzzer     = wave_s;
   assign busy       = busy_q;
   assign active_src = src_q;

endmodule

// File: tb/tb_buzz_sequencer.sv
// Directed scoreboard bench: stimulus queues every expected change of
// {busy, active_src, buzzer}; a monitor pops and checks on each observed change.
module tb_buzz_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       game_en = 1'b0, pause = 1'b0;
   logic       goal_hit = 1'b0, pad_hit = 1'b0, wall_hit = 1'b0;
   logic       buzzer, busy;
   logic [1:0] active_src;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic       busy;
      logic [1:0] src;
      logic       buzz;
   } ev_t;

   ev_t exp_q[$];

   buzz_sequencer #(
      .GOAL_HALF_PERIOD(8),
      .PAD_HALF_PERIOD (4),
      .WALL_HALF_PERIOD(3),
      .GOAL_TICKS      (2),
      .PAD_TICKS       (3),
      .WALL_TICKS      (2),
      .DIV_W           (17),
      .TICK_W          (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .game_en   (game_en),
      .pause     (pause),
      .goal_hit  (goal_hit),
      .pad_hit   (pad_hit),
      .wall_hit  (wall_hit),
      .buzzer    (buzzer),
      .busy      (busy),
      .active_src(active_src)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(int c, logic b, logic [1:0] s, logic z);
      ev_t e;
      e.cyc = c;
      e.busy = b;
      e.src = s;
      e.buzz = z;
      exp_q.push_back(e);
   endtask

   // Tone segment starting high at cycle s, toggling every hp cycles, until cycle e.
   task automatic seg(int s, int e, int hp, logic [1:0] src);
      logic lv;
      lv = 1'b1;
      push(s, 1'b1, src, lv);
      for (int c = s + hp; c < e; c += hp) begin
         lv = ~lv;
         push(c, 1'b1, src, lv);
      end
   endtask

   task automatic go(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(int c, logic g, logic p, logic w, logic e);
      go(c);
      goal_hit = g;
      pad_hit  = p;
      wall_hit = w;
      game_en  = e;
      go(c + 1);
      goal_hit = 1'b0;
      pad_hit  = 1'b0;
      wall_hit = 1'b0;
      game_en  = 1'b0;
   endtask

   initial begin : monitor
      logic [3:0] prev, cur;
      ev_t e;
      prev = 4'b0000;
      forever begin
         @(negedge clk);
         cur = {busy, active_src, buzzer};
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got busy=%b src=%0d buzz=%b, none required",
                        cyc, busy, active_src, buzzer);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.busy !== busy || e.src !== active_src || e.buzz !== buzzer) begin
                  errors++;
                  $display("FAIL event got cyc=%0d busy=%b src=%0d buzz=%b, required cyc=%0d busy=%b src=%0d buzz=%b",
                           cyc, busy, active_src, buzzer, e.cyc, e.busy, e.src, e.buzz);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      go(3);
      rst = 1'b0;
      checks++;
      if ({busy, active_src, buzzer} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state got %b required 0000", {busy, active_src, buzzer});
      end

      // basic pad tone
      seg(11, 151, 4, 2'd2);
      push(151, 1'b0, 2'd0, 1'b0);
      pulse(10, 1'b0, 1'b1, 1'b0, 1'b0);
      pulse(50, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(100, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(150, 1'b0, 1'b0, 1'b0, 1'b1);

      // simultaneous pad + wall: pad first, wall chained with no idle gap
      seg(201, 291, 4, 2'd2);
      seg(291, 351, 3, 2'd1);
      push(351, 1'b0, 2'd0, 1'b0);
      pulse(200, 1'b0, 1'b1, 1'b1, 1'b0);
      pulse(230, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(260, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(290, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(320, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(350, 1'b0, 1'b0, 1'b0, 1'b1);

      // goal preempts wall; wall is not resumed
      seg(401, 411, 3, 2'd1);
      seg(411, 471, 8, 2'd3);
      push(471, 1'b0, 2'd0, 1'b0);
      pulse(400, 1'b0, 1'b0, 1'b1, 1'b0);
      pulse(410, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse(440, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(470, 1'b0, 1'b0, 1'b0, 1'b1);

      // pad retrigger after 2 ticks: 3 more ticks, continuous phase
      seg(501, 611, 4, 2'd2);
      push(611, 1'b0, 2'd0, 1'b0);
      pulse(500, 1'b0, 1'b1, 1'b0, 1'b0);
      pulse(520, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(540, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(550, 1'b0, 1'b1, 1'b0, 1'b0);
      pulse(570, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(590, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(610, 1'b0, 1'b0, 1'b0, 1'b1);

      // pause mid wall tone; wall_hit and game_en during pause have no effect
      seg(701, 721, 3, 2'd1);
      push(721, 1'b1, 2'd1, 1'b0);
      seg(822, 851, 3, 2'd1);
      push(851, 1'b0, 2'd0, 1'b0);
      pulse(700, 1'b0, 1'b0, 1'b1, 1'b0);
      pulse(710, 1'b0, 1'b0, 1'b0, 1'b1);
      go(720);
      pause = 1'b1;
      pulse(750, 1'b0, 1'b0, 1'b1, 1'b0);
      pulse(760, 1'b0, 1'b0, 1'b0, 1'b1);
      go(820);
      pause = 1'b0;
      pulse(850, 1'b0, 1'b0, 1'b0, 1'b1);

      // reset during a goal tone with a pad request pending
      seg(901, 921, 8, 2'd3);
      push(921, 1'b0, 2'd0, 1'b0);
      pulse(900, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse(910, 1'b0, 1'b1, 1'b0, 1'b0);
      go(920);
      rst = 1'b1;
      go(921);
      rst = 1'b0;
      pulse(940, 1'b0, 1'b0, 1'b0, 1'b1);
      pulse(960, 1'b0, 1'b0, 1'b0, 1'b1);

      go(1000);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events got %0d left required 0 (next cyc=%0d)", exp_q.size(), exp_q[0].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
